breakpoint_unit: RTL and testbench
==================================

// Module: breakpoint_unit
// PURPOSE
//  Producer of i_breakpointHitN for the clock/halt block. Holds one user-set breakpoint address
//  (DIP switches + set button) and compares it against each fetched instruction address.
//  On a match it asserts o_breakpointHitN low until the operator presses continue, then
//  re-arms once execution has left the breakpoint address.
// PARAMETERS
//  ADDR_WIDTH  16  width of instruction address, breakpoint register and switch input
// PORTS
//  i_clk               in   1           system clock (same clock as o_clk of the clock block)
//  i_resetn            in   1           asynchronous reset, active-low
//  i_breakpointEnableN in   1           0 = breakpoints enabled (switch level, async to i_clk)
//  i_fetchValid        in   1           1 = i_addr holds the address of an instruction fetched this cycle
//  i_addr              in   ADDR_WIDTH  instruction fetch address
//  i_swBpAddr          in   ADDR_WIDTH  breakpoint address switches (static while the set button is pressed)
//  i_btnSetBp          in   1           set-breakpoint button, 1 = closed, async
//  i_btnContinue       in   1           continue button, 1 = closed, async
//  i_passCount         in   8           [BREAKPOINT_PASS_COUNT_EN only] matches to skip before halting
//  o_breakpointHitN    out  1           0 = halt requested (to clock block)
//  o_bpArmed           out  1           1 = state ARMED (LED)
//  o_bpAddr            out  ADDR_WIDTH  latched breakpoint address (display)
// BEHAVIOUR
//  Reset (async): state DISABLED, r_bpValid=0, o_bpAddr=0, o_breakpointHitN=1, o_bpArmed=0, all syncs 0.
//  Inputs: enableN passes a 2-FF synchroniser; each button passes 2-FF sync + edge register.
//   The 1-cycle pulse is registered 3 rising edges after the button is first sampled closed.
//   The FSM acts on the 4th edge. Holding a button produces exactly one pulse.
//  en = ~enableN_sync & r_bpValid. match = i_fetchValid & (i_addr == r_bpAddr); full-width equality.
//  States (o_breakpointHitN is registered, 0 only in HIT):
//   DISABLED: en -> ARMED.
//   ARMED:    ~en -> DISABLED; match -> HIT (hitN low on the edge after the matching fetch; latency 1).
//   HIT:      hitN held 0. Continue pulse -> SKIP; ~en -> DISABLED.
//   SKIP:     hitN=1; matches ignored. i_fetchValid & (i_addr != r_bpAddr) -> ARMED; ~en -> DISABLED.
//  Set pulse, any state: r_bpAddr <= i_swBpAddr, r_bpValid <= 1, hitN <= 1.
//   Next state ARMED if enableN_sync=0, else DISABLED. Set beats continue and match in the same cycle.
//  ~en beats continue and match in the same cycle.
//  A one-instruction loop at the breakpoint address stays in SKIP. This is intended; the halt
//   block single-steps such loops.
//  Async reset mid-HIT releases the halt immediately (hitN=1 with no clock edge needed).
// CONFIGURATION
//  BREAKPOINT_PASS_COUNT_EN defined:
//   - The set pulse also loads r_passRemaining <= i_passCount.
//   - In ARMED, a match with r_passRemaining != 0 decrements it and goes to SKIP without halting.
//   - A match with r_passRemaining == 0 goes to HIT.
//   - r_passRemaining is not reloaded on continue. Reset value 0.
//  Undefined: the i_passCount port and the counter are absent; every match in ARMED goes to HIT.
// STRUCTURE
//  Shared header debug_defs.vh: state encodings
//   BP_DISABLED=2'd0, BP_ARMED=2'd1, BP_HIT=2'd2, BP_SKIP=2'd3; default DEBUG_ADDR_WIDTH=16.
//  Sub-module btn_sync_edge (2-FF sync + registered rising-edge pulse, async active-low reset).
//   Instantiated for set and continue.
//  The enable switch uses a plain 2-FF sync inline. FSM, comparator, address register and pass
//   counter sit in the top module.
// TESTING
//  1 Reset asserted, then released; no stimulus -> hitN=1, o_bpArmed=0, o_bpAddr=0x0000.
//    FSM stays DISABLED with enableN=0.
//  2 enableN=0, swBpAddr=0x0042, press set; fetch 0x0040, 0x0041, 0x0042 -> hitN=1 through 0x0041.
//    hitN goes 0 on the edge after the 0x0042 fetch and holds for 20 idle cycles.
//  3 From HIT: press continue -> hitN=1 on the 4th edge. Fetch 0x0042 again -> no hit.
//    Fetch 0x0043, then 0x0042 -> hitN=0 again.
//  4 From HIT: set enableN=1 -> hitN=1 within 3 edges.
//    Further 0x0042 fetches -> no hit; o_bpArmed=0.
//  5 BREAKPOINT_PASS_COUNT_EN, i_passCount=2: loop 0x0042,0x0043 -> halt on the 3rd 0x0042 fetch.
//    Without the macro -> halt on the 1st.
//  6 Set and continue pressed in the same cycle while in HIT, swBpAddr=0x0100
//    -> o_bpAddr=0x0100, state ARMED.
//    Async reset pulse mid-HIT -> hitN=1 before the next clock edge.

Source files
------------

// File: rtl/breakpoint_unit_pkg.sv
// Shared definitions for the breakpoint unit: FSM state encodings and the
// default instruction address width.
package breakpoint_unit_pkg;

    // Default width of instruction addresses, breakpoint register and switches.
    localparam int unsigned DEBUG_ADDR_WIDTH = 16;

    // Breakpoint FSM state encodings (kept as plain constants for legacy tools).
    localparam logic [1:0] BP_DISABLED = 2'd0;
    localparam logic [1:0] BP_ARMED    = 2'd1;
    localparam logic [1:0] BP_HIT      = 2'd2;
    localparam logic [1:0] BP_SKIP     = 2'd3;

    // Width of the optional pass counter.
    localparam int unsigned PASS_COUNT_WIDTH = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button conditioner: two-flop synchroniser followed by a registered
// rising-edge detector. A button held closed yields exactly one clock-wide
// pulse, registered on the third rising edge after the button is first sampled
// closed.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Synchronise the button, remember the previous level, register the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/breakpoint_unit.sv
// Single hardware breakpoint. Holds one operator-set breakpoint address and
// compares it with every fetched instruction address; on a match it requests
// a halt (o_breakpointHitN low) until the operator presses continue, then
// re-arms once execution has moved off the breakpoint address.
// Optional feature macro: BREAKPOINT_PASS_COUNT_EN adds i_passCount and a
// counter of matches to skip before halting.
module breakpoint_unit
    import breakpoint_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEBUG_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_breakpointEnableN,
    input  logic                  i_fetchValid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_swBpAddr,
    input  logic                  i_btnSetBp,
    input  logic                  i_btnContinue,
`ifdef BREAKPOINT_PASS_COUNT_EN
    input  logic [7:0]            i_passCount,
`endif
    output logic                  o_breakpointHitN,
    output logic                  o_bpArmed,
    output logic [ADDR_WIDTH-1:0] o_bpAddr
);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic en_n_sync1_q;
    logic en_n_sync2_q;
    logic set_pulse;
    logic cont_pulse;

    // Enable switch is a level; a plain two-flop synchroniser is enough.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            en_n_sync1_q <= 1'b0;
            en_n_sync2_q <= 1'b0;
        end else begin
            en_n_sync1_q <= i_breakpointEnableN;
            en_n_sync2_q <= en_n_sync1_q;
        end
    end

    btn_sync_edge u_set_btn (
        .clk   (i_clk),
        .rst_n (i_resetn),
        .btn   (i_btnSetBp),
        .pulse (set_pulse)
    );

    btn_sync_edge u_cont_btn (
        .clk   (i_clk),
        .rst_n (i_resetn),
        .btn   (i_btnContinue),
        .pulse (cont_pulse)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic                  hit_n_q, hit_n_d;
    logic                  bp_valid_q, bp_valid_d;
    logic [ADDR_WIDTH-1:0] bp_addr_q, bp_addr_d;

    logic en;
    logic addr_eq;
    logic match;

    // Breakpoints only operate once an address has been latched.
    assign en      = ~en_n_sync2_q & bp_valid_q;
    assign addr_eq = (i_addr == bp_addr_q);
    assign match   = i_fetchValid & addr_eq;

`ifdef BREAKPOINT_PASS_COUNT_EN
    logic [PASS_COUNT_WIDTH-1:0] pass_q, pass_d;

    // Matches still to be skipped before the next halt.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            pass_q <= '0;
        end else begin
            pass_q <= pass_d;
        end
    end
`endif

    // Next-state logic: set beats disable, disable beats continue and match.
    always_comb begin
        state_d    = state_q;
        bp_valid_d = bp_valid_q;
        bp_addr_d  = bp_addr_q;
`ifdef BREAKPOINT_PASS_COUNT_EN
        pass_d     = pass_q;
`endif
        if (set_pulse) begin
            bp_addr_d  = i_swBpAddr;
            bp_valid_d = 1'b1;
`ifdef BREAKPOINT_PASS_COUNT_EN
            pass_d     = i_passCount;
`endif
            state_d    = en_n_sync2_q ? BP_DISABLED : BP_ARMED;
        end else if (!en) begin
            state_d = BP_DISABLED;
        end else begin
            unique case (state_q)
                BP_DISABLED: state_d = BP_ARMED;
                BP_ARMED: begin
                    if (match) begin
`ifdef BREAKPOINT_PASS_COUNT_EN
                        if (pass_q != '0) begin
                            pass_d  = pass_q - 8'd1;
                            state_d = BP_SKIP;
                        end else begin
                            state_d = BP_HIT;
                        end
`else
                        state_d = BP_HIT;
`endif
                    end
                end
                BP_HIT: begin
                    if (cont_pulse) begin
                        state_d = BP_SKIP;
                    end
                end
                BP_SKIP: begin
                    // Re-arm only once execution has left the breakpoint address.
                    if (i_fetchValid && !addr_eq) begin
                        state_d = BP_ARMED;
                    end
                end
                default: state_d = BP_DISABLED;
            endcase
        end
        hit_n_d = (state_d != BP_HIT);
    end

    // State registers; async reset also drops the halt request immediately.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= BP_DISABLED;
            hit_n_q    <= 1'b1;
            bp_valid_q <= 1'b0;
            bp_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            hit_n_q    <= hit_n_d;
            bp_valid_q <= bp_valid_d;
            bp_addr_q  <= bp_addr_d;
        end
    end

    assign o_breakpointHitN = hit_n_q;
    assign o_bpArmed        = (state_q == BP_ARMED);
    assign o_bpAddr         = bp_addr_q;

endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed bench for breakpoint_unit: expected outputs are queued as each
// stimulus step is driven and checked one edge later.
module tb_breakpoint_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_n;
    logic        fetch_valid;
    logic [15:0] addr;
    logic [15:0] sw_bp_addr;
    logic        btn_set;
    logic        btn_cont;
    logic [7:0]  pass_count;
    logic        hit_n;
    logic        armed;
    logic [15:0] bp_addr;

`ifdef BREAKPOINT_PASS_COUNT_EN
    localparam int HitOn = 2;
`else
    localparam int HitOn = 0;
`endif

    typedef struct {
        string       tag;
        logic        hit_n;
        logic        armed;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    breakpoint_unit dut (
        .i_clk               (clk),
        .i_resetn            (rst_n),
        .i_breakpointEnableN (enable_n),
        .i_fetchValid        (fetch_valid),
        .i_addr              (addr),
        .i_swBpAddr          (sw_bp_addr),
        .i_btnSetBp          (btn_set),
        .i_btnContinue       (btn_cont),
`ifdef BREAKPOINT_PASS_COUNT_EN
        .i_passCount         (pass_count),
`endif
        .o_breakpointHitN    (hit_n),
        .o_bpArmed           (armed),
        .o_bpAddr            (bp_addr)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic h, input logic a, input logic [15:0] ad);
        exp_t e;
        e.tag   = tag;
        e.hit_n = h;
        e.armed = a;
        e.addr  = ad;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, required one entry");
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        assert (hit_n === e.hit_n) else begin
            n_err++;
            $error("FAIL %s hit_n: got %b required %b", e.tag, hit_n, e.hit_n);
        end
        n_vec++;
        assert (armed === e.armed) else begin
            n_err++;
            $error("FAIL %s armed: got %b required %b", e.tag, armed, e.armed);
        end
        n_vec++;
        assert (bp_addr === e.addr) else begin
            n_err++;
            $error("FAIL %s bp_addr: got %h required %h", e.tag, bp_addr, e.addr);
        end
    endtask

    task automatic fetch(input logic [15:0] a, input string tag, input logic h, input logic arm,
                         input logic [15:0] ad);
        fetch_valid = 1'b1;
        addr        = a;
        push(tag, h, arm, ad);
        tick(1);
        fetch_valid = 1'b0;
        check();
    endtask

    initial begin
        rst_n       = 1'b0;
        enable_n    = 1'b0;
        fetch_valid = 1'b0;
        addr        = 16'h0000;
        sw_bp_addr  = 16'h0000;
        btn_set     = 1'b0;
        btn_cont    = 1'b0;
        pass_count  = 8'd2;

        // 1: reset and idle
        push("in_reset", 1'b1, 1'b0, 16'h0000);
        tick(3);
        check();
        rst_n = 1'b1;
        push("idle_after_reset", 1'b1, 1'b0, 16'h0000);
        tick(6);
        check();

        // 2: set breakpoint 0x0042 and run into it
        sw_bp_addr = 16'h0042;
        btn_set    = 1'b1;
        push("set_edge3", 1'b1, 1'b0, 16'h0000);
        tick(3);
        check();
        push("set_edge4", 1'b1, 1'b1, 16'h0042);
        tick(1);
        check();
        btn_set = 1'b0;
        tick(3);
        fetch(16'h0040, "fetch_40", 1'b1, 1'b1, 16'h0042);
        fetch(16'h0041, "fetch_41", 1'b1, 1'b1, 16'h0042);
        fetch(16'h0042, "fetch_42_hit", 1'b0, 1'b0, 16'h0042);
        push("hit_hold20", 1'b0, 1'b0, 16'h0042);
        tick(20);
        check();

        // 3: continue, no re-hit on same address, re-hit after leaving
        btn_cont = 1'b1;
        push("cont_edge3", 1'b0, 1'b0, 16'h0042);
        tick(3);
        check();
        push("cont_edge4", 1'b1, 1'b0, 16'h0042);
        tick(1);
        check();
        btn_cont = 1'b0;
        tick(3);
        fetch(16'h0042, "skip_42", 1'b1, 1'b0, 16'h0042);
        fetch(16'h0043, "rearm_43", 1'b1, 1'b1, 16'h0042);
        fetch(16'h0042, "rehit_42", 1'b0, 1'b0, 16'h0042);

        // 4: disable while halted
        enable_n = 1'b1;
        push("disable_edge2", 1'b0, 1'b0, 16'h0042);
        tick(2);
        check();
        push("disable_edge3", 1'b1, 1'b0, 16'h0042);
        tick(1);
        check();
        fetch(16'h0042, "disabled_42", 1'b1, 1'b0, 16'h0042);
        enable_n = 1'b0;
        push("reenable", 1'b1, 1'b1, 16'h0042);
        tick(3);
        check();

        // 5: pass count (halts on first match without the feature)
        pass_count = 8'd2;
        btn_set    = 1'b1;
        push("reset_bp", 1'b1, 1'b1, 16'h0042);
        tick(4);
        check();
        btn_set = 1'b0;
        tick(3);
        for (int k = 0; k <= HitOn; k++) begin
            if (k == HitOn) begin
                fetch(16'h0042, "loop_hit", 1'b0, 1'b0, 16'h0042);
            end else begin
                fetch(16'h0042, "loop_pass", 1'b1, 1'b0, 16'h0042);
                fetch(16'h0043, "loop_43", 1'b1, 1'b1, 16'h0042);
            end
        end

        // 6: set and continue together in HIT, then async reset mid-HIT
        sw_bp_addr = 16'h0100;
        btn_set    = 1'b1;
        btn_cont   = 1'b1;
        push("set_and_cont", 1'b1, 1'b1, 16'h0100);
        tick(4);
        check();
        btn_set  = 1'b0;
        btn_cont = 1'b0;
        tick(3);
        fetch(16'h0100, "hit_100", 1'b0, 1'b0, 16'h0100);
        #2;
        rst_n = 1'b0;
        push("async_reset", 1'b1, 1'b0, 16'h0000);
        #1;
        check();
        #1;
        rst_n = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
